// File: rtl/fixed_point_iterative_inv_butterfly_if.sv
// rtl/fixed_point_iterative_inv_butterfly_if.sv - val/rdy bus bundle for the inverse butterfly
interface fixed_point_iterative_inv_butterfly_if #(
    parameter int n = 32
);
    logic         recv_val;
    logic         recv_rdy;
    logic         send_val;
    logic         send_rdy;
    logic [n-1:0] cr;
    logic [n-1:0] cc;
    logic [n-1:0] dr;
    logic [n-1:0] dc;
    logic [n-1:0] wr;
    logic [n-1:0] wc;
    logic [n-1:0] ar;
    logic [n-1:0] ac;
    logic [n-1:0] br;
    logic [n-1:0] bc;

    modport master (
        output recv_val, send_rdy, cr, cc, dr, dc, wr, wc,
        input  recv_rdy, send_val, ar, ac, br, bc
    );

    modport slave (
        input  recv_val, send_rdy, cr, cc, dr, dc, wr, wc,
        output recv_rdy, send_val, ar, ac, br, bc
    );
endinterface

// File: rtl/fixed_point_iterative_inv_butterfly.sv
// rtl/fixed_point_iterative_inv_butterfly.sv - inverse radix-2 butterfly, a=(c+d)/2, b=((c-d)/2)*conj(w)
module fixed_point_iterative_inv_butterfly #(
    parameter int n    = 32,
    parameter int d    = 16,
    parameter int mult = 0
) (
    input  logic clk,
    input  logic reset,
    fixed_point_iterative_inv_butterfly_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_recv_rdy;
    logic         w_send_val;
    logic         w_accept;
    logic         w_mul_done;

    logic [n-1:0] w_ar;
    logic [n-1:0] w_ac;
    logic [n-1:0] w_tr;
    logic [n-1:0] w_tc;
    logic [n-1:0] w_br_fix;
    logic [n-1:0] w_bc_fix;
    logic [n-1:0] w_mul_br;
    logic [n-1:0] w_mul_bc;

    logic [n-1:0] r_ar;
    logic [n-1:0] r_ac;
    logic [n-1:0] r_br;
    logic [n-1:0] r_bc;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_recv_rdy  = 1'b0;
        w_send_val  = 1'b0;
        case (r_state)
            IDLE: begin
                w_recv_rdy = 1'b1;
                if (bus.recv_val) w_state_nxt = (mult == 0) ? CALC : DONE;
            end
            CALC: begin
                if (w_mul_done) w_state_nxt = DONE;
            end
            DONE: begin
                w_send_val = 1'b1;
                if (bus.send_rdy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept     = w_recv_rdy & bus.recv_val;
    assign bus.recv_rdy = w_recv_rdy;
    assign bus.send_val = w_send_val;

    // Sum/difference in n+1 bits then halved, so the n-bit result can never wrap.
    assign w_ar = n'(({bus.cr[n-1], bus.cr} + {bus.dr[n-1], bus.dr}) >> 1);
    assign w_ac = n'(({bus.cc[n-1], bus.cc} + {bus.dc[n-1], bus.dc}) >> 1);
    assign w_tr = n'(({bus.cr[n-1], bus.cr} - {bus.dr[n-1], bus.dr}) >> 1);
    assign w_tc = n'(({bus.cc[n-1], bus.cc} - {bus.dc[n-1], bus.dc}) >> 1);

    // Trivial twiddles: multiply by the conjugate is a swap and/or negate.
    always_comb begin
        w_br_fix = w_tr;
        w_bc_fix = w_tc;
        case (mult)
            2: begin
                w_br_fix = -w_tr;
                w_bc_fix = -w_tc;
            end
            3: begin
                w_br_fix = w_tc;
                w_bc_fix = -w_tr;
            end
            4: begin
                w_br_fix = -w_tc;
                w_bc_fix = w_tr;
            end
            default: begin
                w_br_fix = w_tr;
                w_bc_fix = w_tc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ar <= '0;
            r_ac <= '0;
            r_br <= '0;
            r_bc <= '0;
        end else if (w_accept) begin
            r_ar <= w_ar;
            r_ac <= w_ac;
            if (mult != 0) begin
                r_br <= w_br_fix;
                r_bc <= w_bc_fix;
            end
        end else if (r_state == CALC && w_mul_done) begin
            r_br <= w_mul_br;
            r_bc <= w_mul_bc;
        end
    end

    assign bus.ar = r_ar;
    assign bus.ac = r_ac;
    assign bus.br = r_br;
    assign bus.bc = r_bc;

    generate
        if (mult == 0) begin : g_mul
            localparam int CW = (n > 1) ? $clog2(n) : 1;

            logic [CW-1:0]  r_cnt;
            logic [n-1:0]   r_tr;
            logic [n-1:0]   r_tc;
            logic [n-1:0]   r_wr;
            logic [n-1:0]   r_wc;
            logic [2*n-1:0] r_p1;
            logic [2*n-1:0] r_p2;
            logic [2*n-1:0] r_p3;
            logic [2*n-1:0] r_p4;
            logic [2*n-1:0] w_p1;
            logic [2*n-1:0] w_p2;
            logic [2*n-1:0] w_p3;
            logic [2*n-1:0] w_p4;
            logic [2*n-1:0] w_tr_sh;
            logic [2*n-1:0] w_tc_sh;
            logic           w_last;

            assign w_last  = (int'(r_cnt) == n - 1);
            assign w_tr_sh = {{n{r_tr[n-1]}}, r_tr} << r_cnt;
            assign w_tc_sh = {{n{r_tc[n-1]}}, r_tc} << r_cnt;

            // The multiplier's top bit carries negative weight, so it subtracts.
            always_comb begin
                w_p1 = r_p1;
                w_p2 = r_p2;
                w_p3 = r_p3;
                w_p4 = r_p4;
                if (r_wr[r_cnt]) begin
                    w_p1 = w_last ? r_p1 - w_tr_sh : r_p1 + w_tr_sh;
                    w_p3 = w_last ? r_p3 - w_tc_sh : r_p3 + w_tc_sh;
                end
                if (r_wc[r_cnt]) begin
                    w_p2 = w_last ? r_p2 - w_tc_sh : r_p2 + w_tc_sh;
                    w_p4 = w_last ? r_p4 - w_tr_sh : r_p4 + w_tr_sh;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt <= '0;
                    r_tr  <= '0;
                    r_tc  <= '0;
                    r_wr  <= '0;
                    r_wc  <= '0;
                    r_p1  <= '0;
                    r_p2  <= '0;
                    r_p3  <= '0;
                    r_p4  <= '0;
                end else if (w_accept) begin
                    r_cnt <= '0;
                    r_tr  <= w_tr;
                    r_tc  <= w_tc;
                    r_wr  <= bus.wr;
                    r_wc  <= bus.wc;
                    r_p1  <= '0;
                    r_p2  <= '0;
                    r_p3  <= '0;
                    r_p4  <= '0;
                end else if (r_state == CALC) begin
                    r_cnt <= r_cnt + 1'b1;
                    r_p1  <= w_p1;
                    r_p2  <= w_p2;
                    r_p3  <= w_p3;
                    r_p4  <= w_p4;
                end
            end

            // Dropping the low d bits truncates toward minus infinity.
            assign w_mul_br   = n'((w_p1 + w_p2) >> d);
            assign w_mul_bc   = n'((w_p3 - w_p4) >> d);
            assign w_mul_done = w_last;
        end else begin : g_nomul
            assign w_mul_br   = '0;
            assign w_mul_bc   = '0;
            assign w_mul_done = 1'b1;
        end
    endgenerate
endmodule

// File: tb/tb_fixed_point_iterative_inv_butterfly.sv
// tb/tb_fixed_point_iterative_inv_butterfly.sv - table-driven and random checks of the inverse butterfly
module tb_fixed_point_iterative_inv_butterfly;
    localparam int N  = 32;
    localparam int D  = 16;
    localparam int NV = 11;

    typedef struct {
        logic [31:0] cr, cc, dr, dc, wr, wc;
        logic [31:0] ar, ac, br, bc;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    fixed_point_iterative_inv_butterfly_if #(.n(N)) bus ();
    fixed_point_iterative_inv_butterfly_if #(.n(N)) bus2 ();

    fixed_point_iterative_inv_butterfly #(.n(N), .d(D), .mult(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fixed_point_iterative_inv_butterfly #(.n(N), .d(D), .mult(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // a = floor((c+d)/2), t = floor((c-d)/2), b = t*conj(w) scaled by 2^-D, wrapped to 32 bits.
    function automatic vec_t model(input vec_t v);
        vec_t   r;
        longint scr, scc, sdr, sdc, swr, swc, tr, tc;
        r   = v;
        scr = longint'($signed(v.cr));
        scc = longint'($signed(v.cc));
        sdr = longint'($signed(v.dr));
        sdc = longint'($signed(v.dc));
        swr = longint'($signed(v.wr));
        swc = longint'($signed(v.wc));
        tr  = (scr - sdr) >>> 1;
        tc  = (scc - sdc) >>> 1;
        r.ar = 32'((scr + sdr) >>> 1);
        r.ac = 32'((scc + sdc) >>> 1);
        r.br = 32'((tr * swr + tc * swc) >>> D);
        r.bc = 32'((tc * swr - tr * swc) >>> D);
        return r;
    endfunction

    function automatic vec_t mk(input logic [31:0] cr, cc, dr, dc, wr, wc,
                                input logic [31:0] ar, ac, br, bc);
        vec_t v;
        v.cr = cr; v.cc = cc; v.dr = dr; v.dc = dc; v.wr = wr; v.wc = wc;
        v.ar = ar; v.ac = ac; v.br = br; v.bc = bc;
        return v;
    endfunction

    // Called at #1 after a posedge with the DUT idle; returns once send_val is seen.
    task automatic run(input vec_t v, input string tag, output int lat, output bit busy_ok);
        bus.cr = v.cr; bus.cc = v.cc; bus.dr = v.dr; bus.dc = v.dc;
        bus.wr = v.wr; bus.wc = v.wc;
        bus.recv_val = 1'b1;
        chk({tag, " recv_rdy_idle"}, 128'(bus.recv_rdy), 128'(1));
        @(posedge clk); #1;
        lat = 0;
        busy_ok = 1'b1;
        while (!bus.send_val && lat < 100) begin
            bus.cr = $urandom; bus.cc = $urandom; bus.dr = $urandom;
            bus.dc = $urandom; bus.wr = $urandom; bus.wc = $urandom;
            if (bus.recv_rdy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        bus.recv_val = 1'b0;
        if (bus.recv_rdy) busy_ok = 1'b0;
    endtask

    task automatic release_txn(input string tag);
        bus.send_rdy = 1'b1;
        @(posedge clk); #1;
        bus.send_rdy = 1'b0;
        chk({tag, " send_val_drop"}, 128'(bus.send_val), 128'(0));
        chk({tag, " recv_rdy_back"}, 128'(bus.recv_rdy), 128'(1));
    endtask

    task automatic check_result(input vec_t v, input string tag, input int lat, input bit busy_ok);
        chk({tag, " a"}, {64'(0), bus.ar, bus.ac}, {64'(0), v.ar, v.ac});
        chk({tag, " b"}, {64'(0), bus.br, bus.bc}, {64'(0), v.br, v.bc});
        chk({tag, " latency"}, 128'(lat), 128'(N));
        chk({tag, " busy_rdy_low"}, 128'(busy_ok), 128'(1));
    endtask

    initial begin
        int   lat;
        bit   busy_ok;
        vec_t v;

        reset = 1'b1;
        bus.recv_val = 1'b0; bus.send_rdy = 1'b0;
        bus.cr = '0; bus.cc = '0; bus.dr = '0; bus.dc = '0; bus.wr = '0; bus.wc = '0;
        bus2.recv_val = 1'b0; bus2.send_rdy = 1'b0;
        bus2.cr = '0; bus2.cc = '0; bus2.dr = '0; bus2.dc = '0; bus2.wr = '0; bus2.wc = '0;

        tbl[0] = mk(32'h00030000, 0, 32'h00010000, 0, 32'h00010000, 0,
                    32'h00020000, 0, 32'h00010000, 0);
        tbl[1] = mk(32'h00010000, 32'h00010000, 32'hFFFF0000, 32'h00010000, 0, 32'h00010000,
                    0, 32'h00010000, 0, 32'hFFFF0000);
        tbl[2] = mk(32'h7FFF0000, 32'h80000000, 32'h7FFF0000, 32'h80000000, 32'h00010000, 0,
                    32'h7FFF0000, 32'h80000000, 0, 0);
        for (int i = 3; i < NV; i++) begin
            v = mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 0, 0, 0, 0);
            if (i == 3) begin
                v.cr = 32'h80000000; v.dr = 32'h7FFFFFFF;
                v.wr = 32'h80000000; v.wc = 32'h80000000;
            end
            tbl[i] = model(v);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("reset send_val", 128'(bus.send_val), 128'(0));
        chk("reset recv_rdy", 128'(bus.recv_rdy), 128'(1));
        chk("reset outputs", {bus.ar, bus.ac, bus.br, bus.bc}, 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run(tbl[i], tag, lat, busy_ok);
            check_result(tbl[i], tag, lat, busy_ok);
            release_txn(tag);
        end

        // Backpressure with recv_val asserted in DONE, then a back-to-back transaction.
        run(tbl[0], "bp", lat, busy_ok);
        check_result(tbl[0], "bp", lat, busy_ok);
        for (int k = 0; k < 5; k++) begin
            bus.recv_val = 1'b1;
            bus.cr = $urandom; bus.dr = $urandom;
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d ctl", k), {126'(0), bus.send_val, bus.recv_rdy}, 128'b10);
            chk($sformatf("bp hold%0d out", k), {bus.ar, bus.ac, bus.br, bus.bc},
                {tbl[0].ar, tbl[0].ac, tbl[0].br, tbl[0].bc});
        end
        bus.recv_val = 1'b0;
        release_txn("bp");
        run(tbl[1], "b2b", lat, busy_ok);
        check_result(tbl[1], "b2b", lat, busy_ok);
        release_txn("b2b");

        // Reset ten edges into CALC aborts the transaction.
        bus.cr = tbl[0].cr; bus.cc = tbl[0].cc; bus.dr = tbl[0].dr;
        bus.dc = tbl[0].dc; bus.wr = tbl[0].wr; bus.wc = tbl[0].wc;
        bus.recv_val = 1'b1;
        @(posedge clk); #1;
        bus.recv_val = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort send_val", 128'(bus.send_val), 128'(0));
        chk("abort recv_rdy", 128'(bus.recv_rdy), 128'(1));
        chk("abort outputs", {bus.ar, bus.ac, bus.br, bus.bc}, 128'(0));
        run(tbl[0], "post_abort", lat, busy_ok);
        check_result(tbl[0], "post_abort", lat, busy_ok);
        release_txn("post_abort");

        // mult=2 instance: b = -t, one-edge latency, w ignored.
        for (int i = 0; i < 5; i++) begin
            vec_t e;
            string tag;
            tag = $sformatf("neg%0d", i);
            if (i == 0) begin
                v = mk(32'h00010000, 0, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF,
                       32'h00008000, 0, 32'hFFFF8000, 0);
                e = v;
            end else begin
                v = mk($urandom, $urandom, $urandom, $urandom, 32'hFFFF0000, 0, 0, 0, 0, 0);
                e = model(v);
                v.wr = $urandom; v.wc = $urandom;
            end
            bus2.cr = v.cr; bus2.cc = v.cc; bus2.dr = v.dr; bus2.dc = v.dc;
            bus2.wr = v.wr; bus2.wc = v.wc;
            bus2.recv_val = 1'b1;
            @(posedge clk); #1;
            bus2.recv_val = 1'b0;
            chk({tag, " ctl"}, {126'(0), bus2.send_val, bus2.recv_rdy}, 128'b10);
            chk({tag, " out"}, {bus2.ar, bus2.ac, bus2.br, bus2.bc}, {e.ar, e.ac, e.br, e.bc});
            bus2.send_rdy = 1'b1;
            @(posedge clk); #1;
            bus2.send_rdy = 1'b0;
            chk({tag, " release"}, {126'(0), bus2.send_val, bus2.recv_rdy}, 128'b01);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
